// File: rtl/transfer_scheduler.sv
// Two-scanner serial transfer scheduler: round-robin arbitration, MSB-first
// serialisation of one byte per grant, with peer back-pressure and a wait timeout.
module transfer_scheduler #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       peerReady,
  output logic [1:0] grant,
  output logic       serialOut,
  output logic       serialValid,
  output logic [2:0] bitCount,
  output logic [1:0] done,
  output logic       abortErr,
  output logic       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] GRANT     = 3'd1;
  localparam logic [2:0] WAIT_PEER = 3'd2;
  localparam logic [2:0] SHIFT     = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;
  localparam logic [2:0] ABORT     = 3'd5;

  // Last counter value still allowed to wait; reaching it with the peer idle aborts.
  localparam logic [7:0] LIMIT_LAST = 8'(WAIT_LIMIT - 1);

  logic [2:0] state;
  logic [2:0] nextState;
  logic       owner;
  logic       ptr;
  logic       winner;
  logic       ownsLink;
  logic [7:0] shiftReg;
  logic [7:0] waitCnt;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) winner = ptr;
  end

  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:      nextState = (req != 2'b00) ? GRANT : IDLE;
      GRANT:     nextState = WAIT_PEER;
      WAIT_PEER: begin
        if (peerReady)                 nextState = SHIFT;
        else if (waitCnt >= LIMIT_LAST) nextState = ABORT;
        else                           nextState = WAIT_PEER;
      end
      SHIFT:     nextState = (peerReady && bitCount == 3'd7) ? DONE : SHIFT;
      DONE:      nextState = IDLE;
      ABORT:     nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Owner is captured on leaving IDLE so later req changes cannot disturb the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      ptr      <= 1'b0;
      shiftReg <= 8'h00;
      bitCount <= 3'd0;
      waitCnt  <= 8'h00;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (req != 2'b00) owner <= winner;
        end
        GRANT: begin
          shiftReg <= owner ? data1 : data0;
          bitCount <= 3'd0;
          waitCnt  <= 8'h00;
        end
        WAIT_PEER: begin
          if (!peerReady && waitCnt != 8'hFF) waitCnt <= waitCnt + 8'd1;
        end
        SHIFT: begin
          if (peerReady) begin
            shiftReg <= {shiftReg[6:0], 1'b0};
            bitCount <= bitCount + 3'd1;
          end
        end
        DONE:    ptr <= ~owner;
        ABORT:   ptr <= ~owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    ownsLink    = (state == GRANT) || (state == WAIT_PEER) || (state == SHIFT);
    grant       = ownsLink ? (owner ? 2'b10 : 2'b01) : 2'b00;
    serialOut   = (state == SHIFT) && shiftReg[7];
    serialValid = (state == SHIFT) && peerReady;
    done        = (state == DONE) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    abortErr    = (state == ABORT);
    busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_transfer_scheduler.sv
// Self-checking bench for transfer_scheduler: a transaction-level model is compared
// against the DUT every falling edge, plus directed literal checks per scenario.
module tb_transfer_scheduler;

  localparam int WAIT_LIMIT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       peerReady = 1'b0;
  logic [1:0] grant;
  logic       serialOut;
  logic       serialValid;
  logic [2:0] bitCount;
  logic [1:0] done;
  logic       abortErr;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  transfer_scheduler #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .peerReady(peerReady), .grant(grant), .serialOut(serialOut),
    .serialValid(serialValid), .bitCount(bitCount), .done(done),
    .abortErr(abortErr), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                               input logic p, input int n);
    req = r;
    data0 = d0;
    data1 = d1;
    peerReady = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a transfer is an owner, a whole byte and a count of bits already accepted.
  int         mPhase;
  logic       mOwner;
  logic       mPtr;
  logic [7:0] mByte;
  int         mSent;
  int         mWaited;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mPhase <= 0; mOwner <= 1'b0; mPtr <= 1'b0; mByte <= 8'h00; mSent <= 0; mWaited <= 0;
    end else begin
      case (mPhase)
        0: if (req != 2'b00) begin
             mOwner <= (req == 2'b11) ? mPtr : req[1];
             mPhase <= 1;
           end
        1: begin
             mByte <= mOwner ? data1 : data0;
             mSent <= 0;
             mWaited <= 0;
             mPhase <= 2;
           end
        2: if (peerReady) mPhase <= 3;
           else begin
             mWaited <= mWaited + 1;
             if (mWaited + 1 == WAIT_LIMIT) mPhase <= 5;
           end
        3: if (peerReady) begin
             if (mSent == 7) begin mSent <= 0; mPhase <= 4; end
             else mSent <= mSent + 1;
           end
        default: begin
             mPtr <= !mOwner;
             mPhase <= 0;
           end
      endcase
    end
  end

  always @(posedge clk) cycle++;

  logic       bitLog[$];
  logic [1:0] grantLog[$];
  logic [1:0] prevGrant = 2'b00;
  int         grantCycle = 0;
  int         abortCycle = 0;
  int         abortCount = 0;
  int         done0Count = 0;
  int         done1Count = 0;

  always @(negedge clk) begin
    logic [1:0] expGrant;
    logic       expOut;
    expGrant = (mPhase >= 1 && mPhase <= 3) ? (mOwner ? 2'b10 : 2'b01) : 2'b00;
    expOut   = (mPhase == 3) ? mByte[7 - mSent] : 1'b0;
    checkOutput("grant", 8'(grant), 8'(expGrant));
    checkOutput("serialOut", 8'(serialOut), 8'(expOut));
    checkOutput("serialValid", 8'(serialValid), 8'(mPhase == 3 && peerReady));
    checkOutput("bitCount", 8'(bitCount), 8'(mSent));
    checkOutput("done", 8'(done), (mPhase == 4) ? (mOwner ? 8'd2 : 8'd1) : 8'd0);
    checkOutput("abortErr", 8'(abortErr), 8'(mPhase == 5));
    checkOutput("busy", 8'(busy), 8'(mPhase != 0));
    if (serialValid) bitLog.push_back(serialOut);
    if (grant != 2'b00 && prevGrant == 2'b00) begin
      grantLog.push_back(grant);
      grantCycle = cycle;
    end
    prevGrant = grant;
    if (abortErr) begin abortCount++; abortCycle = cycle; end
    if (done[0]) done0Count++;
    if (done[1]) done1Count++;
  end

  function automatic logic [7:0] loggedByte();
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) if (i < bitLog.size()) b = {b[6:0], bitLog[i]};
    return b;
  endfunction

  task automatic doReset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int d0Before;
    int abBefore;
    #1 rst = 1'b0;
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 3);
    checkOutput("reset grant", 8'(grant), 8'h00);
    checkOutput("reset busy", 8'(busy), 8'h00);
    rst = 1'b1;
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1);

    // Single request, peer always ready.
    bitLog.delete();
    applyStimulus(2'b01, 8'hA5, 8'h00, 1'b1, 1);
    checkOutput("single grant", 8'(grant), 8'h01);
    applyStimulus(2'b00, 8'hA5, 8'h00, 1'b1, 14);
    checkOutput("single bits", 8'(bitLog.size()), 8'd8);
    checkOutput("single byte", loggedByte(), 8'hA5);
    checkOutput("single done", 8'(done0Count), 8'd1);

    // Contention from reset: alternate 0,1,0.
    doReset();
    grantLog.delete();
    applyStimulus(2'b11, 8'h81, 8'h7E, 1'b1, 40);
    applyStimulus(2'b00, 8'h81, 8'h7E, 1'b1, 15);
    checkOutput("contention count", 8'(grantLog.size() >= 3), 8'd1);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("contention grant%0d", i),
                  8'((i < grantLog.size()) ? grantLog[i] : 2'b00), (i == 1) ? 8'h02 : 8'h01);

    // Back-pressure after bit 2 of scanner 1's byte.
    bitLog.delete();
    applyStimulus(2'b10, 8'h00, 8'h3C, 1'b1, 1);
    applyStimulus(2'b00, 8'h00, 8'h3C, 1'b1, 5);
    checkOutput("bp bitCount before", 8'(bitCount), 8'd3);
    applyStimulus(2'b00, 8'h00, 8'h3C, 1'b0, 3);
    checkOutput("bp bitCount held", 8'(bitCount), 8'd3);
    checkOutput("bp valid low", 8'(serialValid), 8'd0);
    applyStimulus(2'b00, 8'h00, 8'h3C, 1'b1, 10);
    checkOutput("bp bits", 8'(bitLog.size()), 8'd8);
    checkOutput("bp byte", loggedByte(), 8'h3C);

    // Timeout with the peer never ready.
    d0Before = done0Count + done1Count;
    applyStimulus(2'b10, 8'h00, 8'h55, 1'b0, 1);
    applyStimulus(2'b00, 8'h00, 8'h55, 1'b0, 25);
    checkOutput("timeout abort count", 8'(abortCount), 8'd1);
    checkOutput("timeout latency", 8'(abortCycle - grantCycle), 8'd16);
    checkOutput("timeout no done", 8'(done0Count + done1Count - d0Before), 8'd0);
    applyStimulus(2'b11, 8'h11, 8'h22, 1'b1, 2);
    checkOutput("timeout ptr to 0", 8'(grant), 8'h01);
    applyStimulus(2'b00, 8'h11, 8'h22, 1'b1, 12);

    // Reset in the middle of SHIFT.
    d0Before = done0Count;
    abBefore = abortCount;
    applyStimulus(2'b01, 8'hF0, 8'h00, 1'b1, 1);
    applyStimulus(2'b00, 8'hF0, 8'h00, 1'b1, 6);
    checkOutput("midreset bitCount before", 8'(bitCount), 8'd4);
    #3 rst = 1'b0;
    #1;
    checkOutput("midreset grant", 8'(grant), 8'h00);
    checkOutput("midreset valid", 8'(serialValid), 8'h00);
    checkOutput("midreset busy", 8'(busy), 8'h00);
    checkOutput("midreset bitCount", 8'(bitCount), 8'h00);
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 2);
    rst = 1'b1;
    checkOutput("midreset no done", 8'(done0Count - d0Before), 8'd0);
    checkOutput("midreset no abort", 8'(abortCount - abBefore), 8'd0);
    bitLog.delete();
    applyStimulus(2'b01, 8'h5A, 8'h00, 1'b1, 1);
    applyStimulus(2'b00, 8'h5A, 8'h00, 1'b1, 14);
    checkOutput("restart byte", loggedByte(), 8'h5A);

    // Request dropped while waiting for the peer.
    d0Before = done0Count;
    bitLog.delete();
    applyStimulus(2'b01, 8'hC3, 8'h00, 1'b0, 2);
    applyStimulus(2'b00, 8'hC3, 8'h00, 1'b0, 3);
    applyStimulus(2'b00, 8'hC3, 8'h00, 1'b1, 12);
    checkOutput("drop done", 8'(done0Count - d0Before), 8'd1);
    checkOutput("drop byte", loggedByte(), 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transfer_scheduler.md
TRANSFER_SCHEDULER -- requirements
Module: transfer_scheduler

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: number of consecutive WAIT_PEER cycles with peerReady low before the transfer aborts (range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  transfer request from local scanner 0 (bit 0) and scanner 1 (bit 1); level-sensitive.
REQ-005 data0  input  8  byte offered by scanner 0; sampled only in GRANT.
REQ-006 data1  input  8  byte offered by scanner 1; sampled only in GRANT.
REQ-007 peerReady  input  1  remote transfer center ready to accept serial bits.
REQ-008 grant  output  2  one-hot owner of the serial link; 00 when no owner.
REQ-009 serialOut  output  1  current serial data bit, MSB first.
REQ-010 serialValid  output  1  serialOut carries a valid bit this cycle.
REQ-011 bitCount  output  3  index of the bit currently driven (0 = MSB).
REQ-012 done  output  2  one-cycle pulse to the owning scanner on successful completion.
REQ-013 abortErr  output  1  one-cycle pulse on peer timeout.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, GRANT, WAIT_PEER, SHIFT, DONE, ABORT; encoded in a registered state vector.
REQ-016 IDLE: if req != 00, next state GRANT; else stay IDLE.
REQ-017 Arbitration: round-robin pointer ptr; if both req bits set, requester ptr wins; if one bit set, that requester wins regardless of ptr.
REQ-018 GRANT (1 cycle): grant = one-hot winner; winner's data latched into 8-bit shift register; bitCount = 0; timeout counter = 0; next WAIT_PEER.
REQ-019 WAIT_PEER: peerReady high -> SHIFT next cycle; peerReady low -> timeout counter +1; when counter reaches WAIT_LIMIT -> ABORT.
REQ-020 SHIFT: serialOut = shiftReg[7], serialValid = peerReady; on a clock edge with peerReady high, shift left by 1 and bitCount +1; with peerReady low, hold shiftReg, bitCount and serialOut (pause, no timeout).
REQ-021 SHIFT exits to DONE on the edge where bitCount = 7 and peerReady = 1; exactly 8 valid bits are emitted per transfer.
REQ-022 DONE (1 cycle): done[owner] = 1, grant = 00, serialValid = 0; ptr = other requester; next IDLE.
REQ-023 ABORT (1 cycle): abortErr = 1, grant = 00, done = 00; ptr = other requester; next IDLE.
REQ-024 grant SHALL remain constant from GRANT through SHIFT; deassertion of req after GRANT SHALL NOT cancel or alter the transfer.
REQ-025 Requests arriving while busy SHALL be ignored until IDLE; minimum gap between transfers is one IDLE cycle.
REQ-026 serialValid SHALL be 0 in all states other than SHIFT; serialOut SHALL be 0 outside SHIFT.
REQ-027 Timeout counter SHALL be 8 bits, saturating; it is cleared in GRANT only.
REQ-028 No illegal state SHALL persist: any unused encoding transitions to IDLE on the next edge.

Reset
REQ-029 rst low SHALL immediately force state IDLE, ptr = 0, shiftReg = 0, bitCount = 0, timeout counter = 0.
REQ-030 During and after reset until the first transfer: grant = 00, serialOut = 0, serialValid = 0, done = 00, abortErr = 0, busy = 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer without a done or abortErr pulse.

Verification
REQ-032 Single request: req = 01, data0 = 8'hA5, peerReady = 1 -> grant = 01 one cycle later, serialOut sequence 1,0,1,0,0,1,0,1 with serialValid high 8 cycles, then done = 01 for one cycle, busy low next cycle.
REQ-033 Contention: req = 11 from reset -> scanner 0 served first; holding req = 11 -> next transfer grant = 10, then 01 (alternation).
REQ-034 Back-pressure: peerReady drops for 3 cycles after bit 2 of data1 = 8'h3C -> bitCount holds at 3, serialValid low 3 cycles, total byte still 0,0,1,1,1,1,0,0.
REQ-035 Timeout: req = 10, peerReady = 0 constantly, WAIT_LIMIT = 15 -> abortErr pulse 16 cycles after grant asserted, done stays 00, ptr moves to 0.
REQ-036 Reset mid-SHIFT: rst low at bitCount = 4 -> outputs reach REQ-030 values asynchronously, no done pulse; after release, req = 01 restarts cleanly at bitCount 0.
REQ-037 Request drop: req = 01 deasserted during WAIT_PEER -> transfer completes normally with done = 01.
